// File: rtl/skew_feeder.sv
// -----------------------------------------------------------------------------
// skew_feeder
//   Host-loadable operand feeder for an N-lane systolic array. An N x K operand
//   matrix is written through a simple write port. A start launches one pass
//   that streams K elements per lane. Lane i is delayed by i cycles, and
//   invalid slots are zero padded. In transpose mode lane i streams column i
//   instead of row i. This mode is only available when N == K. A global enable
//   freezes all state.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset (buffer contents are kept)
//   i_en          advance enable, 0 = stall everything
//   i_start       begin a pass (accepted only when idle and i_en = 1)
//   i_mode        0 = row mode, 1 = transpose mode (sampled at accepted start)
//   i_wr_en       buffer write strobe (honoured only while not busy)
//   i_wr_addr     buffer write address, element A[r][c] lives at r*K + c
//   i_wr_data     buffer write data
//   o_busy        pass in progress
//   o_done        one-cycle pulse alongside the final valid element
//   o_dout        lane i data at bits [i*DW +: DW]
//   o_dout_valid  per-lane valid
// -----------------------------------------------------------------------------
module skew_feeder #(
   parameter int N  = 4,
   parameter int K  = 4,
   parameter int DW = 32,
   parameter int AW = ((N * K) > 1) ? $clog2(N * K) : 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic            i_start,
   input  logic            i_mode,
   input  logic            i_wr_en,
   input  logic [AW-1:0]   i_wr_addr,
   input  logic [DW-1:0]   i_wr_data,
   output logic            o_busy,
   output logic            o_done,
   output logic [N*DW-1:0] o_dout,
   output logic [N-1:0]    o_dout_valid
);

   localparam int DEPTH = N * K;
   localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(K + 1);
   localparam int DCW   = (N > 2) ? $clog2(N - 1) : 1;
   localparam logic [AW:0] DEPTH_A = (AW + 1)'(DEPTH);
   localparam logic TRANSPOSE_OK = (N == K) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2
   } state_t;

   // operand buffer (not reset)
   logic [DW-1:0]   r_mem [DEPTH];

   // sequencer state
   state_t          r_state;
   logic [CW-1:0]   r_k;
   logic [DCW-1:0]  r_drain;
   logic            r_mode;
   logic            r_busy;

   // output registers
   logic [N*DW-1:0] r_dout;
   logic [N-1:0]    r_dout_valid;
   logic            r_done;

   // lane-0 injection and per-lane taps of the skew pipeline
   logic            w_inj_valid;
   logic [CW-1:0]   w_inj_k;
   logic [N-1:0]    w_tap_valid;
   logic [CW-1:0]   w_tap_k [N];
   logic [MAW-1:0]  w_rd_addr [N];
   logic            w_last;
   logic            w_wr_ok;
   logic [MAW-1:0]  w_wr_idx;

   // Writes are blocked for the whole pass, including the busy tail cycle,
   // and addresses past the matrix are dropped.
   assign w_wr_ok  = i_wr_en && !r_busy && ({1'b0, i_wr_addr} < DEPTH_A);
   assign w_wr_idx = MAW'(i_wr_addr);

   // buffer write port, independent of the advance enable
   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         r_mem[w_wr_idx] <= i_wr_data;
      end
   end

   // Only the STREAM state injects valid slots; invalid slots carry k = 0.
   assign w_inj_valid    = (r_state == S_STREAM);
   assign w_inj_k        = (r_state == S_STREAM) ? r_k : {CW{1'b0}};
   assign w_tap_valid[0] = w_inj_valid;
   assign w_tap_k[0]     = w_inj_k;

   generate
      if (N > 1) begin : g_pipe
         logic [N-1:1]  r_pv;
         logic [CW-1:0] r_pk [1:N-1];

         // skew shift register: stage j delays the injected slot by j cycles
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_pv <= {(N-1){1'b0}};
               for (int j = 1; j < N; j++) begin
                  r_pk[j] <= {CW{1'b0}};
               end
            end else if (i_en) begin
               r_pv[1] <= w_inj_valid;
               r_pk[1] <= w_inj_k;
               for (int j = 2; j < N; j++) begin
                  r_pv[j] <= r_pv[j-1];
                  r_pk[j] <= r_pk[j-1];
               end
            end
         end

         for (genvar j = 1; j < N; j++) begin : g_tap
            assign w_tap_valid[j] = r_pv[j];
            assign w_tap_k[j]     = r_pk[j];
         end
      end
   endgenerate

   // The last element of a pass is step K-1 on the most delayed lane.
   assign w_last = w_tap_valid[N-1] && (w_tap_k[N-1] == CW'(K - 1));

   // per-lane read address: row i element k, or column i element k in transpose mode
   always_comb begin
      for (int i = 0; i < N; i++) begin
         if (r_mode) begin
            w_rd_addr[i] = MAW'(32'(w_tap_k[i]) * K + i);
         end else begin
            w_rd_addr[i] = MAW'(i * K + 32'(w_tap_k[i]));
         end
      end
   end

   // pass sequencer: IDLE -> STREAM (K slots) -> DRAIN (N-1 slots) -> IDLE
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_k     <= {CW{1'b0}};
         r_drain <= {DCW{1'b0}};
         r_mode  <= 1'b0;
         r_busy  <= 1'b0;
      end else if (i_en) begin
         case (r_state)
            S_IDLE: begin
               // busy stays high for one idle cycle after the last element,
               // which also keeps writes and restarts out of that cycle
               if (i_start && !r_busy) begin
                  r_state <= S_STREAM;
                  r_k     <= {CW{1'b0}};
                  r_mode  <= TRANSPOSE_OK & i_mode;
                  r_busy  <= 1'b1;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            S_STREAM: begin
               if (r_k == CW'(K - 1)) begin
                  r_k     <= {CW{1'b0}};
                  r_drain <= {DCW{1'b0}};
                  r_state <= (N == 1) ? S_IDLE : S_DRAIN;
               end else begin
                  r_k     <= r_k + CW'(1);
               end
            end
            S_DRAIN: begin
               if (r_drain == DCW'(N - 2)) begin
                  r_state <= S_IDLE;
               end else begin
                  r_drain <= r_drain + DCW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // registered lane outputs with zero padding outside valid slots
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dout       <= {(N*DW){1'b0}};
         r_dout_valid <= {N{1'b0}};
         r_done       <= 1'b0;
      end else if (i_en) begin
         for (int i = 0; i < N; i++) begin
            r_dout[i*DW +: DW] <= w_tap_valid[i] ? r_mem[w_rd_addr[i]] : {DW{1'b0}};
         end
         r_dout_valid <= w_tap_valid;
         r_done       <= w_last;
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_dout       = r_dout;
   assign o_dout_valid = r_dout_valid;

endmodule

// File: tb/tb_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_skew_feeder
//   Self-checking bench for skew_feeder with N = K = 4 and DW = 32. AW is set to 5
//   so that out-of-range addresses can be driven. Each pass pushes its expected
//   {lane, data, cycle} entries into a scoreboard. A negedge monitor pops and
//   compares every fresh valid lane output and checks zero padding. The
//   scenario tasks check busy, done and the special cases inline.
// -----------------------------------------------------------------------------
module tb_skew_feeder;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         start = 1'b0;
   logic         mode = 1'b0;
   logic         wr_en = 1'b0;
   logic [4:0]   wr_addr = 5'd0;
   logic [31:0]  wr_data = 32'd0;
   logic         busy;
   logic         done;
   logic [127:0] dout;
   logic [3:0]   dout_valid;

   typedef struct {
      int          lane;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] model [16];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        adv = 1'b0;

   skew_feeder #(.N(4), .K(4), .DW(32), .AW(5)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_start(start), .i_mode(mode),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .o_busy(busy), .o_done(done), .o_dout(dout), .o_dout_valid(dout_valid)
   );

   always #5 clk = ~clk;

   // edge counter and "outputs updated at this edge" flag
   always @(posedge clk) begin
      cyc <= cyc + 1;
      adv <= en | rst;
   end

   // scoreboard monitor: every fresh valid lane must match the next expected entry
   always @(negedge clk) begin
      if (adv) begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout_valid[i]) begin
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected lane %0d cyc %0d got %h, no output required", i, cyc, dout[i*32 +: 32]);
               end else begin
                  mon_e = exp_q.pop_front();
                  if (mon_e.lane !== i || mon_e.data !== dout[i*32 +: 32] || mon_e.cyc !== cyc) begin
                     errors++;
                     $display("FAIL sb_data got lane %0d data %h cyc %0d, required lane %0d data %h cyc %0d",
                              i, dout[i*32 +: 32], cyc, mon_e.lane, mon_e.data, mon_e.cyc);
                  end
               end
            end else if (dout[i*32 +: 32] !== 32'h0) begin
               errors++;
               $display("FAIL sb_pad lane %0d cyc %0d got %h, required 0", i, cyc, dout[i*32 +: 32]);
            end
         end
      end
   end

   task automatic wr(input int a, input logic [31:0] d);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic kick(input logic m, output int e);
      @(posedge clk); #1;
      start = 1'b1; mode = m;
      @(posedge clk); #1;
      start = 1'b0;
      e = cyc;
   endtask

   // expected entries for one pass, ordered by cycle then lane; edges past
   // stall_at are delayed by stall_len
   task automatic push_pass(input logic m, input int e0, input int stall_at, input int stall_len);
      exp_t ent;
      for (int s = 0; s < 7; s++) begin
         for (int i = 0; i < 4; i++) begin
            int t;
            int c;
            t = s - i;
            if (t >= 0 && t < 4) begin
               c = e0 + 1 + s;
               if (stall_len > 0 && c > stall_at) c = c + stall_len;
               ent.lane = i;
               ent.data = m ? model[t*4 + i] : model[i*4 + t];
               ent.cyc  = c;
               exp_q.push_back(ent);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b required 0", done); end
      checks++; if (dout !== 128'h0) begin errors++; $display("FAIL rst_dout got %h required 0", dout); end
      checks++; if (dout_valid !== 4'h0) begin errors++; $display("FAIL rst_valid got %b required 0", dout_valid); end
      rst = 1'b0;
      en  = 1'b1;
   endtask

   task automatic load_matrix;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            model[r*4 + c] = 32'(16 * r + c);
            wr(r*4 + c, 32'(16 * r + c));
         end
      end
   endtask

   task automatic test_mode(input logic m);
      int e0;
      kick(m, e0);
      push_pass(m, e0, 0, 0);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         checks++; if (busy !== (c < 8)) begin errors++; $display("FAIL mode%0d_busy c=%0d got %b required %b", m, c, busy, c < 8); end
         checks++; if (done !== (c == 7)) begin errors++; $display("FAIL mode%0d_done c=%0d got %b required %b", m, c, done, c == 7); end
         if (m && c == 2) begin
            checks++; if (dout[63:32] !== 32'h01) begin errors++; $display("FAIL mode1_lane1_first got %h required 01", dout[63:32]); end
         end
         if (m && c == 3) begin
            checks++; if (dout[95:64] !== 32'h02) begin errors++; $display("FAIL mode1_lane2_first got %h required 02", dout[95:64]); end
         end
         if (!m && c == 7) begin
            checks++; if (dout_valid !== 4'b1000 || dout[127:96] !== 32'h33) begin
               errors++; $display("FAIL mode0_last got valid %b lane3 %h required 1000 / 33", dout_valid, dout[127:96]);
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mode%0d_drain got %0d pending required 0", m, exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_stall;
      int e0;
      // start with en = 0 must not be accepted
      @(posedge clk); #1; en = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_start_en0 got busy %b required 0", busy); end
      en = 1'b1;
      kick(1'b0, e0);
      push_pass(1'b0, e0, e0 + 3, 2);
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         if (c >= 3 && c <= 5) begin
            for (int i = 0; i < 4; i++) begin
               int t;
               logic [31:0] ev;
               t  = 2 - i;
               ev = (t >= 0) ? model[i*4 + t] : 32'h0;
               checks++;
               if (dout[i*32 +: 32] !== ev || dout_valid[i] !== (t >= 0)) begin
                  errors++; $display("FAIL stall_hold c=%0d lane %0d got %h/%b required %h/%b", c, i, dout[i*32 +: 32], dout_valid[i], ev, t >= 0);
               end
            end
         end
         checks++; if (busy !== (c < 10)) begin errors++; $display("FAIL stall_busy c=%0d got %b required %b", c, busy, c < 10); end
         checks++; if (done !== (c == 9)) begin errors++; $display("FAIL stall_done c=%0d got %b required %b", c, done, c == 9); end
         if (c == 3) en = 1'b0;
         if (c == 5) en = 1'b1;
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain got %0d pending required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_busy_write;
      int e0;
      logic [31:0] want;
      kick(1'b0, e0);
      push_pass(1'b0, e0, 0, 0);
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         checks++; if (busy !== (c < 8)) begin errors++; $display("FAIL bw_busy c=%0d got %b required %b", c, busy, c < 8); end
         checks++; if (done !== (c == 7)) begin errors++; $display("FAIL bw_done c=%0d got %b required %b", c, done, c == 7); end
         if (c == 2) begin wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD; start = 1'b1; end
         if (c == 3) begin wr_en = 1'b0; start = 1'b0; end
      end
      for (int p = 0; p < 2; p++) begin
         if (p == 1) begin
            wr(5, 32'hDEAD);
            model[5] = 32'hDEAD;
         end
         want = (p == 0) ? 32'h11 : 32'hDEAD;
         kick(1'b0, e0);
         push_pass(1'b0, e0, 0, 0);
         for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            checks++; if (busy !== (c < 8)) begin errors++; $display("FAIL bw%0d_busy c=%0d got %b required %b", p, c, busy, c < 8); end
            if (c == 3) begin
               checks++; if (dout[63:32] !== want) begin errors++; $display("FAIL bw%0d_lane1_step1 got %h required %h", p, dout[63:32], want); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bw_drain got %0d pending required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_reset_mid;
      int e0;
      kick(1'b0, e0);
      push_pass(1'b0, e0, 0, 0);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         if (c == 4) begin
            checks++; if (dout !== 128'h0 || dout_valid !== 4'h0) begin errors++; $display("FAIL rmid_out got %h/%b required 0/0", dout, dout_valid); end
            exp_q.delete();
            rst = 1'b0;
         end
         if (c >= 4) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy c=%0d got %b required 0", c, busy); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done c=%0d got %b required 0", c, done); end
         end
         if (c == 3) rst = 1'b1;
      end
      kick(1'b0, e0);
      push_pass(1'b0, e0, 0, 0);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         checks++; if (done !== (c == 7)) begin errors++; $display("FAIL rmid_replay_done c=%0d got %b required %b", c, done, c == 7); end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_drain got %0d pending required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_addr_oob;
      int e0;
      wr(16, 32'hBAD0_0016);
      wr(21, 32'hBAD0_0021);
      @(posedge clk); #1;
      start = 1'b1; mode = 1'b0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hAA;
      model[0] = 32'hAA;
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      e0 = cyc;
      push_pass(1'b0, e0, 0, 0);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         checks++; if (busy !== (c < 8)) begin errors++; $display("FAIL oob_busy c=%0d got %b required %b", c, busy, c < 8); end
         if (c == 1) begin
            checks++; if (dout[31:0] !== 32'hAA || dout_valid[0] !== 1'b1) begin errors++; $display("FAIL oob_lane0_step0 got %h/%b required aa/1", dout[31:0], dout_valid[0]); end
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL oob_drain got %0d pending required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_back_to_back;
      int e0;
      @(posedge clk); #1;
      start = 1'b1; mode = 1'b0;
      @(posedge clk); #1;
      e0 = cyc;
      push_pass(1'b0, e0, 0, 0);
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         checks++; if (busy !== ((c < 8) || (c >= 9 && c < 17))) begin
            errors++; $display("FAIL b2b_busy c=%0d got %b required %b", c, busy, (c < 8) || (c >= 9 && c < 17));
         end
         checks++; if (done !== ((c == 7) || (c == 16))) begin
            errors++; $display("FAIL b2b_done c=%0d got %b required %b", c, done, (c == 7) || (c == 16));
         end
         if (c == 1) mode = 1'b1;
         if (c == 9) begin
            push_pass(1'b1, e0 + 9, 0, 0);
            start = 1'b0;
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d pending required 0", exp_q.size()); exp_q.delete(); end
   endtask

   initial begin
      test_reset();
      load_matrix();
      test_mode(1'b0);
      test_mode(1'b1);
      test_stall();
      test_busy_write();
      test_reset_mid();
      test_addr_oob();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
- Parametrised, host-loadable operand feeder for an N-lane systolic array; successor to the fixed 4x4 operand ROM.
- Holds an N x K operand matrix written through a simple write port.
- On start, streams one K-element vector per lane, with lane i skewed by i cycles and zero padding outside valid slots.
- Adds a runtime transpose mode, a global stall, and a start/busy/done handshake.

Parameters:
- N, 4: number of lanes (array rows); N >= 1.
- K, 4: elements per lane per pass (reduction depth); K >= 1.
- DW, 32: element width in bits.
- AW, $clog2(N*K) (min 1): write address width; address = r*K + c for element A[r][c].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = stall (all state, pipeline and outputs hold).
- start  in  1  begin a pass; accepted only when idle and en=1.
- mode  in  1  0 = row mode, 1 = transpose mode; sampled at accepted start.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address.
- wr_data  in  DW  buffer write data.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse, concurrent with the final valid element.
- dout  out  N*DW  lane i occupies bits [i*DW +: DW].
- dout_valid  out  N  per-lane valid.

Behaviour:
- Reset: busy=0, done=0, dout=0, dout_valid=0, FSM=IDLE, step counter=0, skew pipeline cleared. Buffer contents are not reset.
- Reset asserted mid-pass aborts the pass. No done is issued.
- Mode 0, lane i, step k: output A[i][k].
- Mode 1, lane i, step k: output A[k][i]. Legal only when N==K; if N!=K, mode is forced to 0.
- FSM states:
  - IDLE: on start&en, latch mode, k=0, go to STREAM, busy=1 from that edge.
  - STREAM: each enabled cycle, inject (valid, k) into lane 0 of the skew pipeline; k++. After k=K-1 is injected, go to DRAIN, or straight to IDLE if N==1.
  - DRAIN: inject invalid; lasts N-1 enabled cycles, then go to IDLE, busy=0.
- Skew pipeline: an (N-1)-stage shift register of {valid, k}; lane i reads tap i.
- Output registers: dout[i] = valid_i ? element : 0; dout_valid[i] = valid_i.
- Timing, with start accepted at edge E0 and no stalls:
  - Lane i presents step t after edge E0+1+t+i.
  - busy deasserts after edge E0+K+N.
  - done=1 exactly for the cycle after edge E0+K+N-1, alongside lane N-1 step K-1.
  - Pass length: K+N-1 output cycles.
- Stall (en=0): counter, FSM, pipeline, dout, dout_valid, busy and done all hold. done may therefore stay high across stall cycles; it clears on the next enabled edge.
- Writes:
  - Honoured only when busy=0, independent of en.
  - Ignored when busy=1 or wr_addr >= N*K.
  - A write on the same edge as an accepted start is visible to that pass.
- start while busy=1 is ignored. start with en=0 is not accepted.
- Back-to-back passes: start may be asserted in the cycle busy falls; no gap is required.
- Arithmetic: step counter width $clog2(K+1); no wrap within a pass. Data is passed through unmodified.

Test Plan (N=K=4, DW=32, A[r][c]=0x10*r+c loaded via the write port):
- Mode 0, start pulse at E0 -> lane0 outputs 0x00,0x01,0x02,0x03 after E0+1..E0+4; lane3 outputs 0x30..0x33 after E0+4..E0+7; zeros elsewhere; done high only after E0+7; busy low after E0+8.
- Mode 1 -> lane1 outputs 0x01,0x11,0x21,0x31 after E0+2..E0+5; lane2 starts with 0x02 after E0+3.
- en=0 for 2 cycles after E0+3 -> all outputs frozen for 2 cycles; schedule shifted by 2; done after E0+9.
- During busy, write 0xDEAD to addr 5 and pulse start -> no effect on the current pass; the next pass still outputs 0x11 at lane1 step1; a post-pass write plus restart shows 0xDEAD.
- rst asserted after E0+3 -> next cycle all outputs 0, busy=0, no done; a new start replays full data from the retained buffer.
- Write to addr 16, and a write on the start edge to addr 0 = 0xAA -> addr 16 is dropped with no corruption; lane0 step0 outputs 0xAA.
